// File: rtl/simon_param_core_if.sv
// Host-side bus of the Simon core: request/handshake, key and data words, result and status.
interface simon_param_core_if #(
  parameter int unsigned WORD   = 64,
  parameter int unsigned KWORDS = 4
);
  logic                     start;
  logic                     mode;
  logic                     rekey;
  logic [KWORDS*WORD-1:0]   key;
  logic [2*WORD-1:0]        din;
  logic [2*WORD-1:0]        dout;
  logic                     ready;
  logic                     done;
  logic                     key_ok;

  modport master (
    output start, mode, rekey, key, din,
    input  dout, ready, done, key_ok
  );

  modport slave (
    input  start, mode, rekey, key, din,
    output dout, ready, done, key_ok
  );
endinterface

// File: rtl/simon_param_core.sv
// Iterative Simon 2N/(M*N) cipher core, one round per cycle, with a cached round-key store.
// Encryption and decryption share one round datapath; decryption swaps words on load and
// output and walks the key store backwards.
module simon_param_core #(
  parameter int unsigned WORD   = 64,
  parameter int unsigned KWORDS = 4,
  parameter int unsigned ROUNDS = 72,
  parameter int unsigned ZSEQ   = 4
) (
  input logic            clk,
  input logic            res_n,
  simon_param_core_if.slave bus
);

  localparam int unsigned CntW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned IdxK3 = (KWORDS >= 3) ? KWORDS - 3 : 0;

  // Constant sequences z0..z4; leftmost character is z_j[0], i.e. z_j[i] = Zx[61-i].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] ZSel = (ZSEQ == 0) ? Z0 : (ZSEQ == 1) ? Z1 : (ZSEQ == 2) ? Z2 :
                                 (ZSEQ == 3) ? Z3 : Z4;

  if (KWORDS < 2 || KWORDS > 4) begin : g_bad_kwords
    $error("simon_param_core: KWORDS must be 2, 3 or 4");
  end
  if (ZSEQ > 4) begin : g_bad_zseq
    $error("simon_param_core: ZSEQ must be 0..4");
  end

  typedef enum logic [1:0] {StIdle, StKeygen, StCrypt} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WORD-1:0]         x_q, x_d, y_q, y_d;
  logic                    mode_q, mode_d;
  logic                    key_ok_q, key_ok_d;
  logic [2*WORD-1:0]       dout_q, dout_d;
  logic                    done_q, done_d;
  logic [WORD-1:0]         sr_q [KWORDS];
  logic [WORD-1:0]         sr_d [KWORDS];
  logic [WORD-1:0]         key_ram [ROUNDS];

  logic                    last;
  logic                    ram_we;
  logic [WORD-1:0]         key_word;
  logic [WORD-1:0]         kgen_tmp;
  logic [WORD-1:0]         kgen;
  logic [WORD-1:0]         kw_write;
  logic [31:0]             zpos;
  logic                    z_bit;
  logic [CntW-1:0]         rk_addr;
  logic [WORD-1:0]         rk;
  logic [WORD-1:0]         x_new;

  function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int unsigned r);
    return (v >> r) | (v << (WORD - r));
  endfunction

  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned r);
    return (v << r) | (v >> (WORD - r));
  endfunction

  // Key schedule and round datapath, purely combinational from current state.
  always_comb begin
    last = (cnt_q == CntW'(ROUNDS - 1));

    key_word = '0;
    for (int k = 0; k < int'(KWORDS); k++) begin
      if (cnt_q == CntW'(k)) key_word = bus.key[k*WORD +: WORD];
    end

    // sr_q[0] = k_{i-M}, sr_q[M-1] = k_{i-1}
    zpos     = (32'(cnt_q) - KWORDS) % 62;
    z_bit    = ZSel[6'(61 - zpos)];
    kgen_tmp = ror(sr_q[KWORDS-1], 3);
    if (KWORDS == 4) kgen_tmp = kgen_tmp ^ sr_q[IdxK3];
    kgen_tmp = kgen_tmp ^ ror(kgen_tmp, 1);
    kgen     = ~sr_q[0] ^ kgen_tmp ^ WORD'(z_bit) ^ WORD'(3);
    kw_write = (32'(cnt_q) < KWORDS) ? key_word : kgen;

    rk_addr = mode_q ? (CntW'(ROUNDS - 1) - cnt_q) : cnt_q;
    rk      = key_ram[rk_addr];
    x_new   = y_q ^ (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2) ^ rk;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.start) state_d = (bus.rekey || !key_ok_q) ? StKeygen : StCrypt;
      StKeygen: if (last) state_d = StCrypt;
      StCrypt:  if (last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state per FSM state.
  always_comb begin
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    key_ok_d = key_ok_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    sr_d     = sr_q;
    ram_we   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d = bus.mode;
          cnt_d  = '0;
          // Decrypt loads {y,x} so the forward round runs the inverse.
          x_d    = bus.mode ? bus.din[WORD-1:0] : bus.din[2*WORD-1:WORD];
          y_d    = bus.mode ? bus.din[2*WORD-1:WORD] : bus.din[WORD-1:0];
          if (bus.rekey || !key_ok_q) key_ok_d = 1'b0;
        end
      end
      StKeygen: begin
        ram_we = 1'b1;
        for (int k = 0; k < int'(KWORDS) - 1; k++) sr_d[k] = sr_q[k+1];
        sr_d[KWORDS-1] = kw_write;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) key_ok_d = 1'b1;
      end
      StCrypt: begin
        x_d   = x_new;
        y_d   = x_q;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          dout_d = mode_q ? {x_q, x_new} : {x_new, x_q};
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      key_ok_q <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      for (int k = 0; k < int'(KWORDS); k++) sr_q[k] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      key_ok_q <= key_ok_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      sr_q     <= sr_d;
    end
  end

  // Round-key store: one write per KEYGEN cycle, combinational read; contents need no reset.
  always_ff @(posedge clk) begin
    if (ram_we) key_ram[cnt_q] <= kw_write;
  end

  // FSM outputs.
  always_comb begin
    bus.ready  = (state_q == StIdle);
    bus.done   = done_q;
    bus.dout   = dout_q;
    bus.key_ok = key_ok_q;
  end

endmodule
